spi_receiver: RTL and testbench

Write-side SPI receiver: the peripheral end of the link driven by the `spimaster` write-only SPI master. Samples the asynchronous `sclk`/`mosi`/`csn`/`dcn` lines in the system clock domain and assembles MSB-first bytes, tagging each byte with its data/command flag. Queues complete bytes in a small FIFO that a bus master drains through a 32-bit `read`/`readdata` port. Serves as the display-side model in loopback benches and as a capture block for SPI traffic.

---
 rtl/spi_receiver.sv | 130 +++++++++++++
 tb/tb_spi_receiver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_receiver.sv
// spi_receiver: write-side SPI peripheral. Synchronizes the SPI lines into
// the clk domain, assembles MSB-first bytes tagged with the data/command
// flag, and queues them in a small FIFO read through a 32-bit status word.
module spi_receiver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        csn,
  input  logic        dcn,
  input  logic        read,
  output logic [31:0] readdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] depth_c = 4'(DEPTH);

  // Two-flop synchronizers; bit [1] is the synchronized value.
  logic [1:0] sclk_sync, mosi_sync, csn_sync, dcn_sync;
  logic       sclk_s, mosi_s, csn_s, dcn_s;

  // Shifter state.
  logic       sclk_prev;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       push_pend;
  logic [8:0] push_data;
  logic       rise;

  // FIFO state.
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [3:0]    count;
  logic          overflow;
  logic          push, pop, full, do_write, valid;

  assign sclk_s = sclk_sync[1];
  assign mosi_s = mosi_sync[1];
  assign csn_s  = csn_sync[1];
  assign dcn_s  = dcn_sync[1];
  assign rise   = sclk_s & ~sclk_prev;

  // Bring the asynchronous SPI lines into the clk domain; csn idles deasserted.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      csn_sync  <= 2'b11;
      dcn_sync  <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      csn_sync  <= {csn_sync[0], csn};
      dcn_sync  <= {dcn_sync[0], dcn};
    end
  end

  // Shift in one bit per sclk rise while selected; a completed byte is pushed
  // on the following edge. Deselect discards any partial byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      push_pend <= 1'b0;
      push_data <= '0;
    end else begin
      sclk_prev <= sclk_s;
      push_pend <= 1'b0;
      if (csn_s) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (rise) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          push_pend <= 1'b1;
          push_data <= {dcn_s, shift, mosi_s};
        end
      end
    end
  end

  assign push     = push_pend;
  assign valid    = (count != 4'd0);
  assign full     = (count == depth_c);
  assign pop      = read & valid;
  assign do_write = push & (~full | pop);

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  // NOTE: the storage array is reset too, since the whole FIFO is defined to
  // read back as zero after reset; drop this if a RAM macro is ever used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (do_write && !pop)      count <= count + 4'd1;
      else if (!do_write && pop) count <= count - 4'd1;
      // A read always clears overflow; a read while full also pops, so a
      // same-cycle push is accepted rather than dropped.
      if (read)              overflow <= 1'b0;
      else if (push && full) overflow <= 1'b1;
    end
  end

  // Status word: head entry (masked when empty), valid, overflow, count.
  // NOTE: assigning a default first gives every bit a value on every path,
  // so no latch is inferred.
  always_comb begin
    readdata        = '0;
    readdata[15:12] = count;
    readdata[10]    = overflow;
    readdata[9]     = valid;
    if (valid) readdata[8:0] = mem[rptr];
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Directed self-checking bench for spi_receiver.
module tb_spi_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, mosi, csn, dcn, read;
  logic [31:0] readdata;

  int checks   = 0;
  int failures = 0;

  spi_receiver #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .mosi     (mosi),
    .csn      (csn),
    .dcn      (dcn),
    .read     (read),
    .readdata (readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift the top nbits of b MSB-first; sclk low 3 clk, high 3 clk per bit.
  // With pop_last set, read is raised so that it coincides with the push edge.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc,
                           input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      dcn  = dc;
      wait_cyc(3);
      sclk = 1'b1;
      if (pop_last && i == nbits - 1) begin
        wait_cyc(3);
        read = 1'b1;
        sclk = 1'b0;
        wait_cyc(1);
        read = 1'b0;
      end else begin
        wait_cyc(3);
        sclk = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc, 1'b0);
    wait_cyc(2);
  endtask

  task automatic pulse_read();
    read = 1'b1;
    wait_cyc(1);
    read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (readdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_state: readdata=%h expected=%h", readdata, 32'h0);
    end
    csn = 1'b1;
    send_byte(8'hFF, 1'b1);
    checks++;
    if (readdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL deselected_ignored: readdata=%h expected=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_data_byte();
    csn = 1'b0;
    wait_cyc(3);
    send_byte(8'hC5, 1'b1);
    checks++;
    if (readdata !== 32'h0000_13C5) begin
      failures++;
      $display("FAIL data_byte: readdata=%h expected=%h", readdata, 32'h13C5);
    end
    pulse_read();
    checks++;
    if (readdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL data_pop: readdata=%h expected=%h", readdata, 32'h0);
    end
    // read while empty must leave everything at zero
    pulse_read();
    checks++;
    if (readdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL empty_read: readdata=%h expected=%h", readdata, 32'h0);
    end
  endtask

  task automatic test_command_byte();
    send_byte(8'h5C, 1'b0);
    checks++;
    if (readdata !== 32'h0000_125C) begin
      failures++;
      $display("FAIL command_byte: readdata=%h expected=%h", readdata, 32'h125C);
    end
    pulse_read();
  endtask

  task automatic test_abort();
    send_bits(8'hFF, 5, 1'b1, 1'b0);
    csn = 1'b1;
    wait_cyc(4);
    checks++;
    if (readdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL abort_partial: readdata=%h expected=%h", readdata, 32'h0);
    end
    csn = 1'b0;
    wait_cyc(3);
    send_byte(8'hA5, 1'b1);
    checks++;
    if (readdata !== 32'h0000_13A5) begin
      failures++;
      $display("FAIL abort_then_byte: readdata=%h expected=%h", readdata, 32'h13A5);
    end
    pulse_read();
  endtask

  task automatic test_overflow();
    logic [31:0] exp [3] = '{32'h0000_2303, 32'h0000_1304, 32'h0000_0000};
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    checks++;
    if (readdata !== 32'h0000_4701) begin
      failures++;
      $display("FAIL overflow_full: readdata=%h expected=%h", readdata, 32'h4701);
    end
    read = 1'b1;
    #1;
    checks++;
    if (readdata !== 32'h0000_4701) begin
      failures++;
      $display("FAIL overflow_in_read_cycle: readdata=%h expected=%h", readdata, 32'h4701);
    end
    wait_cyc(1);
    read = 1'b0;
    checks++;
    if (readdata !== 32'h0000_3302) begin
      failures++;
      $display("FAIL overflow_cleared: readdata=%h expected=%h", readdata, 32'h3302);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_read();
      checks++;
      if (readdata !== exp[i]) begin
        failures++;
        $display("FAIL overflow_drain%0d: readdata=%h expected=%h", i, readdata, exp[i]);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp [4] = '{32'h0000_3312, 32'h0000_2313, 32'h0000_1314, 32'h0000_0000};
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
    checks++;
    if (readdata !== 32'h0000_4310) begin
      failures++;
      $display("FAIL full_no_overflow: readdata=%h expected=%h", readdata, 32'h4310);
    end
    send_bits(8'h14, 8, 1'b1, 1'b1);
    wait_cyc(1);
    checks++;
    if (readdata !== 32'h0000_4311) begin
      failures++;
      $display("FAIL full_push_pop: readdata=%h expected=%h", readdata, 32'h4311);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_read();
      checks++;
      if (readdata !== exp[i]) begin
        failures++;
        $display("FAIL push_pop_drain%0d: readdata=%h expected=%h", i, readdata, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    send_bits(8'hFF, 4, 1'b1, 1'b0);
    do_reset();
    checks++;
    if (readdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_mid_byte: readdata=%h expected=%h", readdata, 32'h0);
    end
    wait_cyc(3);
    send_byte(8'h3C, 1'b1);
    checks++;
    if (readdata !== 32'h0000_133C) begin
      failures++;
      $display("FAIL byte_after_reset: readdata=%h expected=%h", readdata, 32'h133C);
    end
  endtask

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    csn   = 1'b1;
    dcn   = 1'b0;
    read  = 1'b0;
    test_reset();
    test_data_byte();
    test_command_byte();
    test_abort();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
